pipe_scoreboard: RTL and testbench
==================================

// Module: pipe_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding controller for the pipelined core. It sits beside decode and
//  tracks the destination of every in-flight instruction in stages 1..DEPTH (1=X, 2=M, 3=W).
//  It produces the decode stall, registered operand-forward selects for the X stage, and
//  sequencing for one long-latency multdiv unit whose result writes back out-of-band.
// PARAMETERS
//  NREG     32  architectural registers; RW=$clog2(NREG)
//  DEPTH    3   tracked stages after decode; SW=$clog2(DEPTH+1)
//  LD_STAGE 2   first stage number at which load data is forwardable
//  MD_LAT   32  multdiv latency in cycles; must be > DEPTH+1
// PORTS
//  clock        in   1   master clock
//  reset        in   1   synchronous, active-low reset (0 = reset)
//  dec_valid    in   1   decode holds a real instruction
//  dec_rs1/rs2  in   RW  source registers
//  dec_rs1_used in   1   rs1 is read; dec_rs2_used: same for rs2
//  dec_rd       in   RW  destination register
//  dec_rd_wr    in   1   instruction writes dec_rd
//  dec_is_load  in   1   instruction is lw
//  dec_is_md    in   1   instruction issues to multdiv
//  flush        in   1   branch/jump taken in X; kill decode instruction
//  stall        out  1   hold PC and F/D latch; insert bubble into X
//  fwd_sel_a/b  out  SW  X-stage operand source: 0=regfile, j=result of stage j
//  md_busy      out  1   multdiv in flight
//  md_wb_valid  out  1   multdiv result writes regfile this cycle
//  md_wb_rd     out  RW  multdiv destination
//  stat_stalls  out  32  stall-cycle count (see CONFIGURATION)
//  stat_fwds    out  32  forwarded-operand count
// BEHAVIOUR
//  - Reset: all stage entries invalid; stall=0; fwd_sel_a/b=0; md_cnt=0; md_busy=0;
//    md_wb_valid=0; md_wb_rd=0; stats=0. Reset mid-multdiv aborts it; no md_wb_valid pulse.
//  - Entry k={valid,rd,wr,is_load}. Every cycle entries shift k->k+1 and the entry in DEPTH retires.
//    Entry 1 loads decode fields iff dec_valid & !stall & !flush; otherwise it loads a bubble.
//    md instructions enter with wr=0.
//  - Match(k, rs): entry k is valid & wr, rd==rs, rs!=0, and rs is used. The nearest match
//    (smallest k) wins. Register 0 never matches.
//  - Load-use: hazard if the nearest match is_load and k<LD_STAGE (default: one bubble).
//  - fwd_sel is registered, 1-cycle latency, and valid in the consumer's X cycle.
//    Value is k+1 if k+1<=DEPTH, else 0 (regfile write-through). It is 0 after a bubble or flush.
//  - Multdiv: issue sets md_cnt=MD_LAT, md_rd=dec_rd; md_cnt decrements to 0.
//    md_wb_valid=(md_cnt==1); md_wb_rd=md_rd; md_busy=(md_cnt!=0).
//    While busy, a hazard is raised for any of the following:
//    - a read of md_rd (md_rd!=0) while md_cnt>1;
//    - a write of md_rd (WAW);
//    - any new dec_is_md;
//    - a register-writing instruction when md_cnt==DEPTH+1 (its W cycle would collide with md_wb).
//  - stall = dec_valid & hazard & !flush. Flush dominates, so PC takes the branch target.
//  - Simultaneous flush + md issue: flush wins and multdiv does not start.
// CONFIGURATION
//  SCOREBOARD_STATS_EN defined: stat_stalls increments on every stall cycle; stat_fwds increments
//  by the number of nonzero fwd_sel_a/b values each cycle. Both saturate at 32'hFFFFFFFF and
//  clear on reset.
//  Not defined: stat_* tied to 0 and no counter flops are built.
// STRUCTURE
//  pipe_pkg holds:
//  - FWD_RF=0 encoding and stage numbers (STG_X=1, STG_M=2, STG_W=3);
//  - the scoreboard entry struct;
//  - opcode constants shared with decode (lw=8, sw=7, addi=5, mul/div ALU ops).
//  Sub-module md_tracker: owns md_cnt, md_rd, md_busy and md_wb_* and exports
//  conflict flags to the hazard logic.
// TESTING
//  1 add r1,r2,r3 then add r4,r1,r1 -> stall=0; next cycle fwd_sel_a=fwd_sel_b=2.
//  2 lw r3,0(r0) then add r4,r3,r0 -> stall=1 for 1 cycle; then fwd_sel_a=3, fwd_sel_b=0.
//  3 addi r0,r0,5 then add r5,r0,r0 -> stall=0, fwd_sel_a=b=0.
//  4 MD_LAT=8: mul r6 then add r7,r6,r6 -> stall 7 cycles; md_wb_valid=1 with md_wb_rd=6
//    on cycle 8; an unrelated writer at md_cnt==4 stalls exactly 1 cycle.
//  5 lw r3 in stage 1, dependent in decode, flush=1 -> stall=0, entry 1 becomes a bubble,
//    next fwd_sel=0.
//  6 reset=0 while md_cnt=5 -> next cycle md_busy=0, and no md_wb_valid in the following
//    MD_LAT cycles.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: forward-select values, stage numbers, scoreboard entry
// layout and the opcode constants decode agrees on.
package pipe_pkg;

  localparam int unsigned FWD_RF = 0;
  localparam int unsigned STG_X  = 1;
  localparam int unsigned STG_M  = 2;
  localparam int unsigned STG_W  = 3;

  // Entry rd is sized for the largest supported register file; narrower files zero-extend.
  localparam int unsigned RD_MAX_W = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                wr;
    logic                is_load;
  } sb_entry_t;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd5,
    OP_SW   = 4'd7,
    OP_LW   = 4'd8
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_MUL  = 4'd10,
    ALU_MULH = 4'd11,
    ALU_DIV  = 4'd12,
    ALU_REM  = 4'd13
  } md_alu_op_e;

endpackage

// File: rtl/pipe_scoreboard_md_tracker.sv
// Long-latency multdiv sequencing: countdown, destination tracking, out-of-band
// write-back strobe and the decode conflict flags that depend on it.
module md_tracker #(
  parameter int unsigned RW     = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned MD_LAT = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          issue,
  input  logic [RW-1:0] dec_rs1,
  input  logic          dec_rs1_used,
  input  logic [RW-1:0] dec_rs2,
  input  logic          dec_rs2_used,
  input  logic [RW-1:0] dec_rd,
  input  logic          dec_rd_wr,
  input  logic          dec_is_md,
  output logic          md_busy,
  output logic          md_wb_valid,
  output logic [RW-1:0] md_wb_rd,
  output logic          raw_conflict,
  output logic          waw_conflict,
  output logic          issue_conflict,
  output logic          wb_conflict
);

  localparam int unsigned CW = $clog2(MD_LAT + 1);

  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic [RW-1:0] md_rd_q, md_rd_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    md_rd_d  = md_rd_q;
    if (issue) begin
      md_cnt_d = CW'(MD_LAT);
      md_rd_d  = dec_rd;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      md_cnt_q <= '0;
      md_rd_q  <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
      md_rd_q  <= md_rd_d;
    end
  end

  assign md_busy     = (md_cnt_q != '0);
  assign md_wb_valid = (md_cnt_q == CW'(1));
  assign md_wb_rd    = md_rd_q;

  // Reads are safe once the count reaches 1: the result is written back that cycle.
  assign raw_conflict = (md_cnt_q > CW'(1)) && (md_rd_q != '0) &&
                        ((dec_rs1_used && dec_rs1 == md_rd_q) ||
                         (dec_rs2_used && dec_rs2 == md_rd_q));
  assign waw_conflict   = md_busy && dec_rd_wr && (dec_rd == md_rd_q);
  assign issue_conflict = md_busy && dec_is_md;
  assign wb_conflict    = (md_cnt_q == CW'(DEPTH + 1)) && dec_rd_wr;

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding controller beside decode. Optional statistics counters are
// built only when SCOREBOARD_STATS_EN is defined.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter  int unsigned NREG     = 32,
  parameter  int unsigned DEPTH    = 3,
  parameter  int unsigned LD_STAGE = 2,
  parameter  int unsigned MD_LAT   = 32,
  localparam int unsigned RW       = $clog2(NREG),
  localparam int unsigned SW       = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dec_valid,
  input  logic [RW-1:0] dec_rs1,
  input  logic [RW-1:0] dec_rs2,
  input  logic          dec_rs1_used,
  input  logic          dec_rs2_used,
  input  logic [RW-1:0] dec_rd,
  input  logic          dec_rd_wr,
  input  logic          dec_is_load,
  input  logic          dec_is_md,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_sel_a,
  output logic [SW-1:0] fwd_sel_b,
  output logic          md_busy,
  output logic          md_wb_valid,
  output logic [RW-1:0] md_wb_rd,
  output logic [31:0]   stat_stalls,
  output logic [31:0]   stat_fwds
);

  localparam int unsigned ENT_W = $bits(sb_entry_t);

  // Element i holds stage i+1; shifting left by one entry advances the pipeline.
  sb_entry_t [DEPTH-1:0] ent_q, ent_d;
  sb_entry_t             new_ent;
  logic [SW-1:0]         fwd_sel_a_q, fwd_sel_a_d, fwd_sel_b_q, fwd_sel_b_d;

  logic          haz_a, haz_b;
  logic [SW-1:0] fwd_a, fwd_b;
  logic          hazard, advance, md_issue;
  logic          raw_c, waw_c, issue_c, wb_c;

  // Returns {load_use_hazard, fwd_select} for the nearest matching producer.
  function automatic logic [SW:0] nearest_match(input sb_entry_t [DEPTH-1:0] ents,
                                                input logic [RW-1:0] rs, input logic used);
    sb_entry_t [DEPTH-1:0] walk;
    sb_entry_t             cur;
    logic                  found;
    logic                  haz;
    logic [SW-1:0]         fwd;
    walk  = ents;
    found = 1'b0;
    haz   = 1'b0;
    fwd   = SW'(FWD_RF);
    for (int unsigned k = STG_X; k <= DEPTH; k++) begin
      cur = walk[0];
      if (!found && used && rs != '0 && cur.valid && cur.wr && cur.rd == RD_MAX_W'(rs)) begin
        found = 1'b1;
        haz   = cur.is_load && (k < LD_STAGE);
        fwd   = (k < DEPTH) ? SW'(k + 1) : SW'(FWD_RF);
      end
      walk = walk >> ENT_W;
    end
    return {haz, fwd};
  endfunction

  assign {haz_a, fwd_a} = nearest_match(ent_q, dec_rs1, dec_rs1_used);
  assign {haz_b, fwd_b} = nearest_match(ent_q, dec_rs2, dec_rs2_used);

  assign hazard   = haz_a || haz_b || raw_c || waw_c || issue_c || wb_c;
  assign stall    = dec_valid && hazard && !flush;
  assign advance  = dec_valid && !stall && !flush;
  assign md_issue = advance && dec_is_md;

  md_tracker #(
    .RW     (RW),
    .DEPTH  (DEPTH),
    .MD_LAT (MD_LAT)
  ) u_md_tracker (
    .clock          (clock),
    .reset          (reset),
    .issue          (md_issue),
    .dec_rs1        (dec_rs1),
    .dec_rs1_used   (dec_rs1_used),
    .dec_rs2        (dec_rs2),
    .dec_rs2_used   (dec_rs2_used),
    .dec_rd         (dec_rd),
    .dec_rd_wr      (dec_rd_wr),
    .dec_is_md      (dec_is_md),
    .md_busy        (md_busy),
    .md_wb_valid    (md_wb_valid),
    .md_wb_rd       (md_wb_rd),
    .raw_conflict   (raw_c),
    .waw_conflict   (waw_c),
    .issue_conflict (issue_c),
    .wb_conflict    (wb_c)
  );

  always_comb begin
    new_ent = '0;
    if (advance) begin
      new_ent.valid   = 1'b1;
      new_ent.rd      = RD_MAX_W'(dec_rd);
      new_ent.wr      = dec_rd_wr && !dec_is_md;
      new_ent.is_load = dec_is_load;
    end
    ent_d       = ent_q << ENT_W;
    ent_d[0]    = new_ent;
    fwd_sel_a_d = advance ? fwd_a : SW'(FWD_RF);
    fwd_sel_b_d = advance ? fwd_b : SW'(FWD_RF);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ent_q       <= '0;
      fwd_sel_a_q <= '0;
      fwd_sel_b_q <= '0;
    end else begin
      ent_q       <= ent_d;
      fwd_sel_a_q <= fwd_sel_a_d;
      fwd_sel_b_q <= fwd_sel_b_d;
    end
  end

  assign fwd_sel_a = fwd_sel_a_q;
  assign fwd_sel_b = fwd_sel_b_q;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stat_stalls_q, stat_stalls_d, stat_fwds_q, stat_fwds_d;
  logic [1:0]  fwd_inc;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_inc       = 2'(fwd_sel_a_q != '0) + 2'(fwd_sel_b_q != '0);
    fwd_sum       = {1'b0, stat_fwds_q} + 33'(fwd_inc);
    stat_fwds_d   = fwd_sum[32] ? '1 : fwd_sum[31:0];
    stat_stalls_d = (stat_stalls_q == '1) ? stat_stalls_q : stat_stalls_q + 32'(stall);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_stalls_q <= '0;
      stat_fwds_q   <= '0;
    end else begin
      stat_stalls_q <= stat_stalls_d;
      stat_fwds_q   <= stat_fwds_d;
    end
  end

  assign stat_stalls = stat_stalls_q;
  assign stat_fwds   = stat_fwds_q;
`else
  assign stat_stalls = '0;
  assign stat_fwds   = '0;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard (MD_LAT=8): per-cycle stall/multdiv checks and a
// queue of expected forward selects, pushed at decode and popped one cycle later.
module tb_pipe_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_used, dec_rs2_used, dec_rd_wr, dec_is_load, dec_is_md, flush;
  logic        stall, md_busy, md_wb_valid;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [4:0]  md_wb_rd;
  logic [31:0] stat_stalls, stat_fwds;

  int checks = 0;
  int errors = 0;
  int exp_stalls = 0;
  int exp_fwds = 0;
  logic [3:0] fwd_exp_q [$];

  always #5 clock = ~clock;

  pipe_scoreboard #(
    .MD_LAT (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rs1_used (dec_rs1_used),
    .dec_rs2_used (dec_rs2_used),
    .dec_rd       (dec_rd),
    .dec_rd_wr    (dec_rd_wr),
    .dec_is_load  (dec_is_load),
    .dec_is_md    (dec_is_md),
    .flush        (flush),
    .stall        (stall),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .md_busy      (md_busy),
    .md_wb_valid  (md_wb_valid),
    .md_wb_rd     (md_wb_rd),
    .stat_stalls  (stat_stalls),
    .stat_fwds    (stat_fwds)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_rs1_used = 1'b0; dec_rs2_used = 1'b0; dec_rd_wr = 1'b0;
    dec_is_load = 1'b0; dec_is_md = 1'b0; flush = 1'b0;
  endtask

  task automatic ins(input int rs1, input int u1, input int rs2, input int u2,
                     input int rd, input int wr, input int ld, input int md);
    dec_valid = 1'b1;
    dec_rs1 = 5'(rs1); dec_rs1_used = (u1 != 0);
    dec_rs2 = 5'(rs2); dec_rs2_used = (u2 != 0);
    dec_rd = 5'(rd); dec_rd_wr = (wr != 0);
    dec_is_load = (ld != 0); dec_is_md = (md != 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef SCOREBOARD_STATS_EN
    check({tag, "_stat_stalls"}, stat_stalls, 32'(exp_stalls));
    check({tag, "_stat_fwds"}, stat_fwds, 32'(exp_fwds));
`else
    check({tag, "_stat_stalls"}, stat_stalls, 32'd0);
    check({tag, "_stat_fwds"}, stat_fwds, 32'd0);
`endif
  endtask

  // One decode cycle: check this cycle's outputs, queue the forward selects this
  // decode should produce next cycle, then advance to just after the next edge.
  task automatic cyc(input logic e_stall, input logic e_busy, input logic e_wbv,
                     input logic [1:0] nfa, input logic [1:0] nfb);
    logic [3:0] exp;
    #1;
    check("stall", 32'(stall), 32'(e_stall));
    exp = fwd_exp_q.pop_front();
    check("fwd_sel_a", 32'(fwd_sel_a), 32'(exp[3:2]));
    check("fwd_sel_b", 32'(fwd_sel_b), 32'(exp[1:0]));
    check("md_busy", 32'(md_busy), 32'(e_busy));
    check("md_wb_valid", 32'(md_wb_valid), 32'(e_wbv));
    exp_stalls += int'(e_stall);
    exp_fwds += int'(exp[3:2] != 2'd0) + int'(exp[1:0] != 2'd0);
    fwd_exp_q.push_back({nfa, nfb});
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fwd_a", 32'(fwd_sel_a), 32'd0);
    check("rst_fwd_b", 32'(fwd_sel_b), 32'd0);
    check("rst_md_busy", 32'(md_busy), 32'd0);
    check("rst_md_wb_valid", 32'(md_wb_valid), 32'd0);
    check("rst_md_wb_rd", 32'(md_wb_rd), 32'd0);
    check_stats("rst");
    reset = 1'b1;
    fwd_exp_q.push_back(4'h0);

    // add r1,r2,r3 ; add r4,r1,r1 -> forward from M on both operands
    ins(2, 1, 3, 1, 1, 1, 0, 0);  cyc(0, 0, 0, 2'd0, 2'd0);
    ins(1, 1, 1, 1, 4, 1, 0, 0);  cyc(0, 0, 0, 2'd2, 2'd2);
    idle();                       cyc(0, 0, 0, 2'd0, 2'd0);
    idle();                       cyc(0, 0, 0, 2'd0, 2'd0);

    // lw r3,0(r0) ; add r4,r3,r0 -> one load-use bubble, then forward from W
    ins(0, 1, 0, 0, 3, 1, 1, 0);  cyc(0, 0, 0, 2'd0, 2'd0);
    ins(3, 1, 0, 1, 4, 1, 0, 0);  cyc(1, 0, 0, 2'd0, 2'd0);
    ins(3, 1, 0, 1, 4, 1, 0, 0);  cyc(0, 0, 0, 2'd3, 2'd0);
    idle();                       cyc(0, 0, 0, 2'd0, 2'd0);

    // addi r0,r0,5 ; add r5,r0,r0 -> r0 never matches
    ins(0, 1, 0, 0, 0, 1, 0, 0);  cyc(0, 0, 0, 2'd0, 2'd0);
    ins(0, 1, 0, 1, 5, 1, 0, 0);  cyc(0, 0, 0, 2'd0, 2'd0);
    idle();                       cyc(0, 0, 0, 2'd0, 2'd0);

    // lw r3 ; flushed dependent add r9 ; add r10,r9 must not see r9
    ins(0, 1, 0, 0, 3, 1, 1, 0);  cyc(0, 0, 0, 2'd0, 2'd0);
    ins(3, 1, 3, 1, 9, 1, 0, 0);  flush = 1'b1;  cyc(0, 0, 0, 2'd0, 2'd0);
    flush = 1'b0;
    ins(9, 1, 0, 0, 10, 1, 0, 0); cyc(0, 0, 0, 2'd0, 2'd0);
    // flush together with a mul: multdiv must not start
    ins(1, 1, 2, 1, 11, 1, 0, 1); flush = 1'b1;  cyc(0, 0, 0, 2'd0, 2'd0);
    idle();                       cyc(0, 0, 0, 2'd0, 2'd0);

    // mul r6 ; add r7,r6,r6 -> 7 stall cycles, write-back on the 8th
    ins(1, 1, 2, 1, 6, 1, 0, 1);  cyc(0, 0, 0, 2'd0, 2'd0);
    ins(6, 1, 6, 1, 7, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 2'd0, 2'd0);
    #1;
    check("md_wb_rd_r6", 32'(md_wb_rd), 32'd6);
    cyc(0, 1, 1, 2'd0, 2'd0);
    idle();                       cyc(0, 0, 0, 2'd0, 2'd0);

    // mul r6 again: structural, WAW and write-back-slot conflicts
    ins(1, 1, 2, 1, 6, 1, 0, 1);  cyc(0, 0, 0, 2'd0, 2'd0);
    idle();                       cyc(0, 1, 0, 2'd0, 2'd0);
    ins(1, 1, 2, 1, 11, 1, 0, 1); cyc(1, 1, 0, 2'd0, 2'd0);
    ins(1, 1, 2, 1, 6, 1, 0, 0);  cyc(1, 1, 0, 2'd0, 2'd0);
    idle();                       cyc(0, 1, 0, 2'd0, 2'd0);
    ins(1, 1, 2, 1, 8, 1, 0, 0);  cyc(1, 1, 0, 2'd0, 2'd0);
    ins(1, 1, 2, 1, 8, 1, 0, 0);  cyc(0, 1, 0, 2'd0, 2'd0);
    idle();                       cyc(0, 1, 0, 2'd0, 2'd0);
    #1;
    check("md_wb_rd_r6_second", 32'(md_wb_rd), 32'd6);
    cyc(0, 1, 1, 2'd0, 2'd0);
    cyc(0, 0, 0, 2'd0, 2'd0);
    check_stats("mid");

    // mul r12, reset while md_cnt==5 -> aborted, no write-back afterwards
    ins(1, 1, 2, 1, 12, 1, 0, 1); cyc(0, 0, 0, 2'd0, 2'd0);
    idle();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 2'd0, 2'd0);
    reset = 1'b0;                 cyc(0, 1, 0, 2'd0, 2'd0);
    reset = 1'b1;
    exp_stalls = 0;
    exp_fwds = 0;
    check("post_rst_md_wb_rd", 32'(md_wb_rd), 32'd0);
    check_stats("post_rst");
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 2'd0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
